// File: rtl/sm_sequencer.sv
// -----------------------------------------------------------------------------
// sm_sequencer
//   Store-Multiple engine. On start, the register mask is walked from R0 up to
//   R(NREG-1). For every set bit i, Ri is read from the register file and
//   written to data memory at consecutive word addresses beginning at
//   base_addr. The core stalls while busy is high.
//
// Ports
//   clock        rising-edge clock
//   reset        synchronous, active-high reset (aborts a running sequence)
//   start        one-cycle request, sampled only in IDLE
//   imm_field    register mask, bit i set = store Ri
//   base_addr    first memory word address, sampled with start
//   rf_rd_addr   register-file read index
//   rf_rd_data   combinational register-file read data for rf_rd_addr
//   mem_addr     memory write address
//   mem_wr_data  memory write data (pass-through of rf_rd_data)
//   mem_wr_en    write request, held until mem_ready accepts it
//   mem_ready    memory accepts on an edge with mem_wr_en=1 and mem_ready=1
//   busy         high in every state except IDLE
//   done         one-cycle pulse when the sequence completes
//   store_count  registers stored by the last/current sequence
// -----------------------------------------------------------------------------
module sm_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int NREG   = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic [NREG-1:0]             imm_field,
    input  logic [ADDR_W-1:0]           base_addr,
    output logic [$clog2(NREG)-1:0]     rf_rd_addr,
    input  logic [DATA_W-1:0]           rf_rd_data,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wr_data,
    output logic                        mem_wr_en,
    input  logic                        mem_ready,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(NREG+1)-1:0]   store_count
);

    localparam int IDX_W = $clog2(NREG);
    localparam int CNT_W = $clog2(NREG + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [NREG-1:0]    mask_reg, mask_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic [IDX_W-1:0]   cur_idx_reg, cur_idx_next;
    logic [CNT_W-1:0]   count_reg, count_next;

    // Isolate the lowest set bit of the remaining mask: bit gi survives only
    // if no lower bit is set.
    logic [NREG-1:0]    low_onehot;
    logic [IDX_W-1:0]   low_idx;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_low
            if (gi == 0) begin : g_first
                assign low_onehot[gi] = mask_reg[gi];
            end else begin : g_rest
                assign low_onehot[gi] = mask_reg[gi] & ~(|mask_reg[gi-1:0]);
            end
        end
    endgenerate

    always_comb begin
        low_idx = '0;
        for (int i = 0; i < NREG; i++) begin
            if (low_onehot[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            mask_reg    <= '0;
            addr_reg    <= '0;
            cur_idx_reg <= '0;
            count_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            mask_reg    <= mask_next;
            addr_reg    <= addr_next;
            cur_idx_reg <= cur_idx_next;
            count_reg   <= count_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        mask_next    = mask_reg;
        addr_next    = addr_reg;
        cur_idx_next = cur_idx_reg;
        count_next   = count_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    mask_next  = imm_field;
                    addr_next  = base_addr;
                    count_next = '0;
                    state_next = (imm_field != '0) ? SCAN : DONE;
                end
            end
            SCAN: begin
                cur_idx_next = low_idx;
                mask_next    = mask_reg & ~low_onehot;
                state_next   = WRITE;
            end
            WRITE: begin
                if (mem_ready) begin
                    // Address wraps naturally modulo 2^ADDR_W.
                    addr_next  = addr_reg + ADDR_W'(1);
                    count_next = count_reg + CNT_W'(1);
                    state_next = (mask_reg == '0) ? DONE : SCAN;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The write request is masked by reset so that the memory never sees an
    // acceptance on the edge that aborts a sequence.
    assign mem_wr_en   = (state_reg == WRITE) && !reset;
    assign rf_rd_addr  = cur_idx_reg;
    assign mem_addr    = addr_reg;
    assign mem_wr_data = rf_rd_data;
    assign busy        = (state_reg != IDLE);
    assign done        = (state_reg == DONE);
    assign store_count = count_reg;

endmodule

// File: doc/sm_sequencer.md
Name: sm_sequencer

Overview:
- Store-Multiple (SM) engine for the RISC datapath; the write-to-memory counterpart of the Load-Multiple path.
- On start, walks the 8-bit register mask from R0 to R7.
- For each set bit i, reads Ri from the register file and writes it to data memory at consecutive word addresses starting at the base address (contents of RA).
- The core stalls on busy.

Parameters:
- DATA_W, 16, register/memory data width
- ADDR_W, 16, memory word-address width
- NREG, 8, number of architectural registers; mask width

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; sampled only in IDLE
- imm_field  input  8  register mask; bit i set = store Ri
- base_addr  input  16  start word address (RA contents), sampled with start
- rf_rd_addr  output  3  register-file read index
- rf_rd_data  input  16  register-file combinational read data for rf_rd_addr
- mem_addr  output  16  memory write address
- mem_wr_data  output  16  memory write data
- mem_wr_en  output  1  write request; held until accepted
- mem_ready  input  1  memory accepts write on clock edge where mem_wr_en=1 and mem_ready=1
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when the sequence completes
- store_count  output  4  number of registers stored by the last/current sequence

Behaviour:
- Reset: the synchronous clock edge with reset=1 forces state=IDLE.
  - Clears mask, addr register, cur_idx and store_count to 0.
  - Outputs: mem_wr_en=0, busy=0, done=0, rf_rd_addr=0, mem_addr=0.
  - Reset mid-sequence aborts it.
  - No write is issued on the reset edge or the following cycle.
- States: IDLE, SCAN, WRITE, DONE.
- IDLE:
  - start=1 latches mask<=imm_field, addr<=base_addr, store_count<=0.
  - Next state is SCAN if imm_field!=0, else DONE (no writes).
  - start while not IDLE is ignored.
- SCAN (1 cycle):
  - cur_idx <= index of lowest set bit of mask.
  - Clear that bit in mask.
  - Next state WRITE.
- WRITE:
  - rf_rd_addr=cur_idx, mem_wr_en=1, mem_addr=addr, mem_wr_data=rf_rd_data (combinational pass-through).
  - Outputs stay stable while mem_ready=0; stall is unbounded.
  - On the edge with mem_ready=1: addr<=addr+1, store_count<=store_count+1; next state DONE if mask==0, else SCAN.
- DONE: done=1 for exactly one cycle, busy=1, next state IDLE. A start in DONE is ignored.
- Ordering: strictly ascending register index; the lowest set register goes to base_addr.
- Address arithmetic: modulo 2^16; 16'hFFFF+1 wraps to 16'h0000.
- Latency (mem_ready tied 1, n set bits, n>=1):
  - Start sampled at edge 0.
  - k-th write (k=1..n) is presented in cycle 2k.
  - done is high in cycle 2n+1.
  - busy is high cycles 1..2n+1.
  - Empty mask: done in cycle 1.
- The register file is not written while busy=1 (core stall guarantee), so rf_rd_data is stable across WRITE stalls.
- store_count holds its final value until the next accepted start or reset.
- mem_wr_en is never high outside WRITE.

Test Plan:
- Full mask:
  - Stimulus: reset, then start with imm_field=8'hFF, base_addr=16'h0040, Ri=16'h1000+i, mem_ready=1.
  - Response: 8 writes at 0x0040..0x0047 with data 0x1000..0x1007.
  - Response: done in cycle 17, store_count=8.
- Sparse mask:
  - Stimulus: imm_field=8'b1010_0010, base=16'h0100.
  - Response: writes R1->0x0100, R5->0x0101, R7->0x0102.
  - Response: done cycle 7, store_count=3.
- Empty mask:
  - Stimulus: imm_field=0.
  - Response: no mem_wr_en, done pulse in cycle 1, store_count=0, busy high for one cycle only.
- Backpressure:
  - Stimulus: imm_field=8'h03, mem_ready low for 3 cycles on the first write.
  - Response: mem_addr/mem_wr_data/mem_wr_en stable for 4 cycles.
  - Response: then R1 written at base+1; done delayed by 3 cycles.
- Wrap and ignored start:
  - Stimulus: base=16'hFFFF, imm_field=8'h0C.
  - Response: R2->0xFFFF, R3->0x0000.
  - Stimulus: start re-pulsed mid-sequence with a different mask.
  - Response: the re-pulsed start has no effect.
- Reset mid-operation:
  - Stimulus: reset asserted during the second WRITE of imm_field=8'h0F.
  - Response: next cycle state IDLE, mem_wr_en=0, busy=0, no done pulse.
  - Response: a subsequent start runs a clean sequence.
